// File: rtl/mc_ctrl.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback and drives the datapath/memory strobes.
module mc_ctrl #(
   parameter int          CNT_W   = 32,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic             clk,
   input  logic             rstd,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_rdy,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic [1:0]       rf_wsel,
   output logic [1:0]       rf_asel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   state_t cur_state, nxt_state;

   logic is_halt, is_r, is_ialu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_bad;
   logic taken, retire;
   state_t retire_target;

   // Halt opcode wins over every other class, so a HALT_OP override can never be
   // mistaken for an ordinary instruction.
   always_comb begin
      is_halt = (opcode == HALT_OP);
      is_r    = !is_halt && (opcode == 6'd0);
      is_ialu = !is_halt && (opcode[5:3] == 3'b001);
      is_lw   = !is_halt && (opcode == 6'd35);
      is_sw   = !is_halt && (opcode == 6'd43);
      is_beq  = !is_halt && (opcode == 6'd4);
      is_bne  = !is_halt && (opcode == 6'd5);
      is_j    = !is_halt && (opcode == 6'd2);
      is_jal  = !is_halt && (opcode == 6'd3);
      is_bad  = !(is_halt || is_r || is_ialu || is_lw || is_sw ||
                  is_beq || is_bne || is_j || is_jal);
   end

   assign taken         = (is_beq && zero) || (is_bne && !zero);
   assign retire_target = run ? FETCH : IDLE;

   always_comb begin
      retire = 1'b0;
      case (cur_state)
         DECODE:  retire = is_j || is_jal;
         EXEC:    retire = is_beq || is_bne;
         MEM:     retire = is_sw && mem_rdy;
         WB:      retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         IDLE:   if (run) nxt_state = FETCH;
         FETCH:  if (mem_rdy) nxt_state = DECODE;
         DECODE: begin
            if (is_halt || is_bad)     nxt_state = HALT;
            else if (is_j || is_jal)   nxt_state = retire_target;
            else                       nxt_state = EXEC;
         end
         EXEC: begin
            if (is_r || is_ialu)       nxt_state = WB;
            else if (is_lw || is_sw)   nxt_state = MEM;
            else if (is_beq || is_bne) nxt_state = retire_target;
            else                       nxt_state = HALT;
         end
         MEM:    if (mem_rdy) nxt_state = is_sw ? retire_target : WB;
         WB:     nxt_state = retire_target;
         HALT:   nxt_state = HALT;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = 2'd0;
      rf_we   = 1'b0;
      rf_wsel = 2'd0;
      rf_asel = 2'd0;
      case (cur_state)
         FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_rdy;
         end
         DECODE: begin
            if (is_j || is_jal) begin
               pc_we  = 1'b1;
               pc_sel = 2'd2;
            end
            if (is_jal) begin
               rf_we   = 1'b1;
               rf_wsel = 2'd2;
               rf_asel = 2'd2;
            end
         end
         EXEC: begin
            if (is_beq || is_bne) begin
               pc_we  = 1'b1;
               pc_sel = taken ? 2'd1 : 2'd0;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = is_sw;
            pc_we   = is_sw && mem_rdy;
         end
         WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            rf_wsel = is_lw ? 2'd1 : 2'd0;
            rf_asel = is_r ? 2'd0 : 2'd1;
         end
         default: ;
      endcase
   end

   // The illegal flag is sticky until reset so software can tell a fault halt
   // from a deliberate one.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (cur_state == DECODE && is_bad) illegal <= 1'b1;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   assign state  = cur_state;
   assign halted = (cur_state == HALT);

endmodule
